// File: rtl/gray_window_gen.sv
// gray_window_gen
// Streaming 3x3 neighbourhood generator for grayscale frames. Pixels arrive
// in raster order, one per accepted handshake. The two previous rows are kept
// in internal line buffers. For every interior pixel, a registered 3x3 window
// and its centre coordinates come out one cycle after the accept.
//
// Ports
//   clk, reset   : clock and synchronous active-high reset
//   start        : begin a frame (sampled only while idle)
//   in_valid     : in_pixel is valid this cycle
//   in_pixel     : raster-order gray pixel
//   in_ready     : high while a frame is running and pixels are accepted
//   win_valid    : win / win_x / win_y carry a new window this cycle
//   win          : element (r,c) at bits [PIX_W*(3r+c) +: PIX_W],
//                  r=0 oldest row, c=0 oldest column
//   win_x, win_y : centre coordinates of the window
//   frame_done   : one-cycle pulse that coincides with the last window
module gray_window_gen #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int PIX_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [PIX_W-1:0]   in_pixel,
  output logic               in_ready,
  output logic               win_valid,
  output logic [9*PIX_W-1:0] win,
  output logic [9:0]         win_x,
  output logic [8:0]         win_y,
  output logic               frame_done
);

  localparam int         AW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [9:0]         x;
  logic [8:0]         y;
  logic               accept;
  logic               interior;
  logic               frame_end;
  logic [AW-1:0]      addr;
  logic [PIX_W-1:0]   lb_a [WIDTH];
  logic [PIX_W-1:0]   lb_b [WIDTH];
  logic [PIX_W-1:0]   top;
  logic [PIX_W-1:0]   mid;
  logic [3*PIX_W-1:0] col_l;
  logic [3*PIX_W-1:0] col_m;
  logic [3*PIX_W-1:0] col_new;
  logic [9*PIX_W-1:0] win_next;

  assign accept    = in_valid && in_ready;
  assign interior  = (x >= 10'd2) && (y >= 9'd2);
  assign frame_end = (x == X_LAST) && (y == Y_LAST);
  assign addr      = x[AW-1:0];

  // lb_a holds row y-2 and lb_b holds row y-1 at column x. Reading both and
  // shifting them up by one row on each accept gives the full column.
  assign top     = lb_a[addr];
  assign mid     = lb_b[addr];
  assign col_new = {in_pixel, mid, top};

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && frame_end) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Columns x-2, x-1 and x. Column vectors store row r at [PIX_W*r +: PIX_W].
  always_comb begin
    win_next = '0;
    for (int r = 0; r < 3; r++) begin
      win_next[PIX_W*(3*r)     +: PIX_W] = col_l[PIX_W*r +: PIX_W];
      win_next[PIX_W*(3*r + 1) +: PIX_W] = col_m[PIX_W*r +: PIX_W];
      win_next[PIX_W*(3*r + 2) +: PIX_W] = col_new[PIX_W*r +: PIX_W];
    end
  end

  // The line buffers have no reset. Interior gating keeps stale contents off
  // the output.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_a[addr] <= mid;
      lb_b[addr] <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      col_l      <= '0;
      col_m      <= '0;
      win_valid  <= 1'b0;
      win        <= '0;
      win_x      <= '0;
      win_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      win_valid  <= accept && interior;
      frame_done <= accept && frame_end;
      if (state == IDLE && start) begin
        x <= '0;
        y <= '0;
      end else if (accept) begin
        // The column registers are not cleared on row wrap. The x>=2 gate
        // hides the columns left over from the previous row.
        col_l <= col_m;
        col_m <= col_new;
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? 9'd0 : y + 9'd1;
        end else begin
          x <= x + 10'd1;
        end
        if (interior) begin
          win   <= win_next;
          win_x <= x - 10'd1;
          win_y <= y - 9'd1;
        end
      end
    end
  end

endmodule
